// File: rtl/loader_pkg.sv
// loader_pkg: shared constants and FSM state encoding for prog_loader
package loader_pkg;
    localparam int W_BYTE = 8;
    localparam int W_OPCODE = 4;
    localparam logic [W_OPCODE-1:0] HALT_OP = 4'b0000;
    typedef logic [2:0] state_t;
    localparam state_t LOAD = 3'd0;
    localparam state_t START = 3'd1;
    localparam state_t RUN = 3'd2;
    localparam state_t DUMP = 3'd3;
    localparam state_t DONE = 3'd4;
endpackage

// File: rtl/byte_packer.sv
// byte_packer: packs a little-endian byte stream into W_INSTR-bit words
// Ports: clk, rst, clear (drop partial word), data/valid (byte in),
//        word/word_valid (complete word, word_valid high for 1 cycle).
module byte_packer
    import loader_pkg::*;
#(
    parameter int W_INSTR = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic [W_BYTE-1:0]  data,
    input  logic               valid,
    output logic [W_INSTR-1:0] word,
    output logic               word_valid
);
    localparam int NB = W_INSTR / W_BYTE;
    localparam int W_CNT = NB > 1 ? $clog2(NB) : 1;
    localparam logic [W_CNT-1:0] CNT_LAST = W_CNT'(NB - 1);
    logic [W_CNT-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= valid && cnt == CNT_LAST;
            if (valid) begin
                for (int i = 0; i < NB; i++)
                    if (cnt == W_CNT'(i)) word[i*W_BYTE +: W_BYTE] <= data;
                cnt <= cnt == CNT_LAST ? '0 : cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/prog_loader.sv
// prog_loader: loads IRAM from a byte stream, runs the CPU, dumps DRAM as bytes
// Ports: clk/rst; s_data/s_valid/s_ready byte input; iram_we/iram_addr/iram_din;
//        dram_addr/dram_dout (1-cycle read); mem_sel (1 = loader owns memories);
//        start/idle CPU handshake; m_data/m_valid/m_ready/m_last dump output;
//        restart/done; timeout_err (sticky).
// Option: PROG_LOADER_CHECKSUM_EN appends a negated mod-256 sum byte to the dump.
module prog_loader
    import loader_pkg::*;
#(
    parameter int W_INSTR = 16,
    parameter int IRAM_DEPTH = 256,
    parameter int DRAM_DEPTH = 256,
    parameter int RUN_TIMEOUT = 2**20,
    localparam int W_IADDR = $clog2(IRAM_DEPTH),
    localparam int W_DADDR = $clog2(DRAM_DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         s_data,
    input  logic               s_valid,
    output logic               s_ready,
    output logic               iram_we,
    output logic [W_IADDR-1:0] iram_addr,
    output logic [W_INSTR-1:0] iram_din,
    output logic [W_DADDR-1:0] dram_addr,
    input  logic [7:0]         dram_dout,
    output logic               mem_sel,
    output logic               start,
    input  logic               idle,
    output logic [7:0]         m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_last,
    input  logic               restart,
    output logic               done,
    output logic               timeout_err
);
    localparam int W_RUN = RUN_TIMEOUT > 1 ? $clog2(RUN_TIMEOUT) : 1;
    localparam logic [W_RUN-1:0] RUN_LAST = W_RUN'(RUN_TIMEOUT > 0 ? RUN_TIMEOUT - 1 : 0);
    localparam logic [W_IADDR-1:0] IRAM_LAST = W_IADDR'(IRAM_DEPTH - 1);
    localparam logic [W_DADDR-1:0] DRAM_LAST = W_DADDR'(DRAM_DEPTH - 1);
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam bit DATA_LAST = 1'b0;
    logic [7:0] sum;
    logic csum_ph;
`else
    localparam bit DATA_LAST = 1'b1;
`endif
    state_t state;
    logic [W_RUN-1:0] run_cnt;
    logic rd_wait, word_valid, halt_hit, run_idle, run_to, at_last;
    logic [W_INSTR-1:0] word;
    byte_packer #(.W_INSTR(W_INSTR)) packer (
        .clk(clk),
        .rst(rst),
        .clear(state != LOAD),
        .data(s_data),
        .valid(s_valid && s_ready),
        .word(word),
        .word_valid(word_valid)
    );
    assign s_ready = state == LOAD;
    assign mem_sel = !(state == START || state == RUN);
    assign done = state == DONE;
    assign iram_we = word_valid && state == LOAD;
    assign iram_din = word;
    assign halt_hit = iram_we && (word[W_OPCODE-1:0] == HALT_OP || iram_addr == IRAM_LAST);
    // The CPU has not yet reacted to start in the first RUN cycle, so idle is stale there.
    assign run_idle = run_cnt != '0 && idle;
    assign run_to = RUN_TIMEOUT != 0 && run_cnt == RUN_LAST;
    assign at_last = dram_addr == DRAM_LAST;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
            iram_addr <= '0;
            dram_addr <= '0;
            run_cnt <= '0;
            rd_wait <= 1'b0;
            start <= 1'b0;
            m_data <= '0;
            m_valid <= 1'b0;
            m_last <= 1'b0;
            timeout_err <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum <= '0;
            csum_ph <= 1'b0;
`endif
        end else begin
            start <= state == START;
            case (state)
                LOAD: begin
                    if (iram_we && !halt_hit) iram_addr <= iram_addr + 1'b1;
                    if (halt_hit) state <= START;
                end
                START: begin
                    run_cnt <= '0;
                    state <= RUN;
                end
                RUN: begin
                    run_cnt <= run_cnt + W_RUN'(run_cnt != '1);
                    if (run_to && !run_idle) timeout_err <= 1'b1;
                    if (run_idle || run_to) begin
                        state <= DUMP;
                        dram_addr <= '0;
                        rd_wait <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
                        sum <= '0;
                        csum_ph <= 1'b0;
`endif
                    end
                end
                DUMP: begin
                    // rd_wait spends one cycle per byte covering the DRAM read latency.
                    if (!m_valid) begin
                        rd_wait <= !rd_wait;
                        if (rd_wait) begin
                            m_data <= dram_dout;
                            m_valid <= 1'b1;
                            m_last <= DATA_LAST && at_last;
                        end
                    end else if (m_ready) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        sum <= sum + m_data;
                        if (!csum_ph && at_last) begin
                            m_data <= 8'd0 - (sum + m_data);
                            m_last <= 1'b1;
                            csum_ph <= 1'b1;
                        end else begin
                            m_valid <= 1'b0;
                            m_last <= 1'b0;
                            if (csum_ph) state <= DONE;
                            else dram_addr <= dram_addr + 1'b1;
                        end
`else
                        m_valid <= 1'b0;
                        m_last <= 1'b0;
                        if (at_last) state <= DONE;
                        else dram_addr <= dram_addr + 1'b1;
`endif
                    end
                end
                DONE: begin
                    if (restart) begin
                        state <= LOAD;
                        iram_addr <= '0;
                        timeout_err <= 1'b0;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: scoreboard-based bench for prog_loader
module tb_prog_loader;
    logic clk = 1'b0, rst = 1'b1;
    logic [7:0] s_data = '0;
    logic s_valid = 1'b0, s_ready;
    logic iram_we;
    logic [7:0] iram_addr;
    logic [15:0] iram_din;
    logic [7:0] dram_addr;
    logic [7:0] dram_dout = '0;
    logic mem_sel, start, idle;
    logic [7:0] m_data;
    logic m_valid, m_ready, m_last;
    logic restart = 1'b0;
    logic done, timeout_err;
    int n_tests = 0, n_fail = 0, n_stall = 0, busy = 0;
    logic cpu_to = 1'b0, rand_ready = 1'b0;
    logic [15:0] prog[$];
    logic [23:0] iram_q[$];
    logic [8:0] dump_q[$];
    logic stall_prev = 1'b0, held_l;
    logic [7:0] held_d;
    logic [23:0] exp_w;
    logic [8:0] exp_b;

    always #5 clk = ~clk;

    prog_loader #(.W_INSTR(16), .IRAM_DEPTH(256), .DRAM_DEPTH(256), .RUN_TIMEOUT(100)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .iram_we(iram_we), .iram_addr(iram_addr), .iram_din(iram_din),
        .dram_addr(dram_addr), .dram_dout(dram_dout), .mem_sel(mem_sel),
        .start(start), .idle(idle), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_last(m_last), .restart(restart), .done(done),
        .timeout_err(timeout_err)
    );

    // DRAM holds DRAM[k] = k with one cycle of read latency.
    always @(posedge clk) dram_dout <= dram_addr;

    // CPU model: busy for a while after start, or (cpu_to) idle only in the start cycle.
    initial begin
        idle = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (start) begin
                idle = cpu_to;
                busy = cpu_to ? 200 : 5;
            end else if (busy > 0) begin
                busy--;
                idle = 1'b0;
            end else idle = 1'b1;
        end
    end

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Scoreboard: IRAM writes and dump handshakes pop their expected values here.
    always @(negedge clk) begin
        if (rst) stall_prev = 1'b0;
        else begin
            if (iram_we) begin
                n_tests++;
                if (iram_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL iram_write unexpected addr=%h data=%h", iram_addr, iram_din);
                end else begin
                    exp_w = iram_q.pop_front();
                    if ({iram_addr, iram_din} !== exp_w) begin
                        n_fail++;
                        $display("FAIL iram_write got addr/data=%h want=%h", {iram_addr, iram_din}, exp_w);
                    end
                end
            end
            if (stall_prev) begin
                n_tests++;
                if (m_valid !== 1'b1 || m_data !== held_d || m_last !== held_l) begin
                    n_fail++;
                    $display("FAIL stall_hold got v=%b d=%h l=%b want v=1 d=%h l=%b", m_valid, m_data, m_last, held_d, held_l);
                end
            end
            stall_prev = m_valid && !m_ready;
            if (stall_prev) n_stall++;
            held_d = m_data;
            held_l = m_last;
            if (m_valid && m_ready) begin
                n_tests++;
                if (dump_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL dump_byte unexpected got last/data=%h", {m_last, m_data});
                end else begin
                    exp_b = dump_q.pop_front();
                    if ({m_last, m_data} !== exp_b) begin
                        n_fail++;
                        $display("FAIL dump_byte got last/data=%h want=%h", {m_last, m_data}, exp_b);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task tick;
        @(posedge clk); #1;
    endtask

    task send_byte(input logic [7:0] b);
        s_data = b;
        s_valid = 1'b1;
        for (int i = 0; i < 20 && s_ready !== 1'b1; i++) tick;
        if (s_ready !== 1'b1) begin
            n_tests++; n_fail++;
            $display("FAIL send_byte s_ready got=%b want=1", s_ready);
        end
        tick;
        s_valid = 1'b0;
    endtask

    task load_prog;
        foreach (prog[i]) begin
            iram_q.push_back({8'(i), prog[i]});
            send_byte(prog[i][7:0]);
            send_byte(prog[i][15:8]);
        end
    endtask

    task push_dump;
        for (int k = 0; k < 256; k++) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            dump_q.push_back({1'b0, 8'(k)});
`else
            dump_q.push_back({k == 255, 8'(k)});
`endif
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        dump_q.push_back({1'b1, 8'h80});
`endif
    endtask

    task wait_done(input int budget);
        for (int i = 0; i < budget && done !== 1'b1; i++) tick;
        if (done !== 1'b1) begin
            n_tests++; n_fail++;
            $display("FAIL wait_done got done=%b want=1", done);
        end
    endtask

    task restart_pulse;
        restart = 1'b1;
        tick;
        restart = 1'b0;
        tick;
    endtask

    task test_reset;
        rst = 1'b1;
        tick; tick;
        n_tests++;
        if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready got=%b want=1", s_ready); end
        n_tests++;
        if (mem_sel !== 1'b1) begin n_fail++; $display("FAIL reset_mem_sel got=%b want=1", mem_sel); end
        n_tests++;
        if ({iram_we, start, m_valid, m_last, done, timeout_err} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b want=000000", {iram_we, start, m_valid, m_last, done, timeout_err});
        end
        n_tests++;
        if ({iram_addr, dram_addr} !== 16'h0) begin n_fail++; $display("FAIL reset_addr got=%h want=0000", {iram_addr, dram_addr}); end
        rst = 1'b0;
        tick;
    endtask

    task test_halt_load;
        prog = {16'h2111, 16'h4332, 16'h0000};
        load_prog;
        n_tests++;
        if (iram_we !== 1'b1 || iram_addr !== 8'd2) begin n_fail++; $display("FAIL halt_we got we=%b addr=%h want we=1 addr=02", iram_we, iram_addr); end
        tick;
        n_tests++;
        if ({s_ready, start, mem_sel} !== 3'b000) begin n_fail++; $display("FAIL halt_start_state got rdy/start/sel=%b want=000", {s_ready, start, mem_sel}); end
        tick;
        n_tests++;
        if (start !== 1'b1) begin n_fail++; $display("FAIL halt_start_pulse got=%b want=1", start); end
        tick;
        n_tests++;
        if ({start, s_ready} !== 2'b00) begin n_fail++; $display("FAIL halt_start_end got start/rdy=%b want=00", {start, s_ready}); end
        n_tests++;
        if (iram_q.size() != 0) begin n_fail++; $display("FAIL halt_writes got pending=%0d want=0", iram_q.size()); end
    endtask

    task test_dump;
        n_tests++;
        if (mem_sel !== 1'b0) begin n_fail++; $display("FAIL run_mem_sel got=%b want=0", mem_sel); end
        push_dump;
        wait_done(3000);
        n_tests++;
        if (dump_q.size() != 0) begin n_fail++; $display("FAIL dump_count got pending=%0d want=0", dump_q.size()); end
        n_tests++;
        if ({done, mem_sel, timeout_err, s_ready} !== 4'b1100) begin
            n_fail++;
            $display("FAIL dump_done got done/sel/to/rdy=%b want=1100", {done, mem_sel, timeout_err, s_ready});
        end
    endtask

    task test_backpressure;
        restart_pulse;
        n_tests++;
        if ({done, s_ready} !== 2'b01) begin n_fail++; $display("FAIL restart_state got done/rdy=%b want=01", {done, s_ready}); end
        rand_ready = 1'b1;
        prog = {16'h0000};
        load_prog;
        push_dump;
        wait_done(6000);
        rand_ready = 1'b0;
        n_tests++;
        if (dump_q.size() != 0) begin n_fail++; $display("FAIL bp_count got pending=%0d want=0", dump_q.size()); end
        n_tests++;
        if (n_stall == 0) begin n_fail++; $display("FAIL bp_stalls got=%0d want>0", n_stall); end
    endtask

    task test_full_iram;
        restart_pulse;
        prog.delete();
        for (int k = 0; k < 256; k++) prog.push_back({8'(k), 8'h01});
        load_prog;
        n_tests++;
        if (iram_we !== 1'b1 || iram_addr !== 8'hff) begin n_fail++; $display("FAIL full_we got we=%b addr=%h want we=1 addr=ff", iram_we, iram_addr); end
        tick;
        n_tests++;
        if ({s_ready, start} !== 2'b00) begin n_fail++; $display("FAIL full_stop got rdy/start=%b want=00", {s_ready, start}); end
        tick;
        n_tests++;
        if (start !== 1'b1) begin n_fail++; $display("FAIL full_start got=%b want=1", start); end
        push_dump;
        wait_done(3000);
        n_tests++;
        if (iram_q.size() + dump_q.size() != 0) begin n_fail++; $display("FAIL full_pending got=%0d want=0", iram_q.size() + dump_q.size()); end
    endtask

    task test_timeout;
        int n;
        logic early;
        restart_pulse;
        cpu_to = 1'b1;
        prog = {16'h0000};
        load_prog;
        push_dump;
        for (int i = 0; i < 10 && start !== 1'b1; i++) tick;
        n = 0;
        early = 1'b0;
        while (mem_sel === 1'b0 && n < 300) begin
            if (timeout_err !== 1'b0) early = 1'b1;
            n++;
            tick;
        end
        n_tests++;
        if (n != 100) begin n_fail++; $display("FAIL timeout_cycles got=%0d want=100", n); end
        n_tests++;
        if (timeout_err !== 1'b1 || early) begin n_fail++; $display("FAIL timeout_flag got=%b early=%b want=1 early=0", timeout_err, early); end
        wait_done(3000);
        cpu_to = 1'b0;
        n_tests++;
        if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky got=%b want=1", timeout_err); end
        n_tests++;
        if (dump_q.size() != 0) begin n_fail++; $display("FAIL timeout_dump got pending=%0d want=0", dump_q.size()); end
    endtask

    task test_restart_clear;
        restart_pulse;
        n_tests++;
        if ({timeout_err, done, s_ready} !== 3'b001 || iram_addr !== 8'h0) begin
            n_fail++;
            $display("FAIL restart_clear got to/done/rdy=%b addr=%h want=001 addr=00", {timeout_err, done, s_ready}, iram_addr);
        end
    endtask

    task test_rst_midword;
        send_byte(8'haa);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        n_tests++;
        if ({s_ready, iram_we} !== 2'b10) begin n_fail++; $display("FAIL midword_rst got rdy/we=%b want=10", {s_ready, iram_we}); end
        prog = {16'h1234, 16'h0000};
        load_prog;
        push_dump;
        wait_done(3000);
        n_tests++;
        if (iram_q.size() + dump_q.size() != 0) begin n_fail++; $display("FAIL midword_pending got=%0d want=0", iram_q.size() + dump_q.size()); end
    endtask

    initial begin
        test_reset;
        test_halt_load;
        test_dump;
        test_backpressure;
        test_full_iram;
        test_timeout;
        test_restart_clear;
        test_rst_midword;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
